agnus_sprite_dma: RTL

- Sprite DMA sequencer on the Agnus side: the writer for the Denise sprite register block.
- Holds the eight sprite pointers and tracks each sprite's vertical start and stop lines.
- In the fixed sprite slots of every line, requests chip-RAM fetches that write SPRxPOS, SPRxCTL, SPRxDATA and SPRxDATB over the register bus.
- Sits beside the bitplane, copper and audio DMA units; its outputs go to the Agnus bus arbiter and address mux.

---
 rtl/agnus_sprite_dma_if.sv | 23 ++
 rtl/agnus_sprite_dma.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/agnus_sprite_dma_if.sv
// Beam, register-bus and chip-bus signals shared between the sprite DMA
// sequencer and the Agnus arbiter/address mux.
interface agnus_sprite_dma_if;
  logic [8:0]  hpos;
  logic [8:0]  vpos;
  logic        vbl_end;
  logic        dmaen;
  logic [8:1]  reg_address_in;
  logic [15:0] data_in;
  logic        dma;
  logic [8:1]  reg_address_out;
  logic [20:1] address_out;

  modport slave (
    input  hpos, vpos, vbl_end, dmaen, reg_address_in, data_in,
    output dma, reg_address_out, address_out
  );

  modport master (
    output hpos, vpos, vbl_end, dmaen, reg_address_in, data_in,
    input  dma, reg_address_out, address_out
  );
endinterface

// File: rtl/agnus_sprite_dma.sv
// Sprite DMA sequencer: owns the eight sprite pointers, snoops SPRxPOS/CTL for
// vertical start/stop and requests the two sprite words per line in the fixed slots.
module agnus_sprite_dma #(
  parameter logic [8:0] SPRPTBASE     = 9'h120,
  parameter logic [8:0] SPRPOSCTLBASE = 9'h140,
  parameter logic [7:0] SPRSLOTSTART  = 8'h15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk7_en,
  agnus_sprite_dma_if.slave bus
);
  typedef enum logic {WAIT = 1'b0, ARMED = 1'b1} spr_state_t;
  typedef enum logic [1:0] {NONE = 2'd0, CTL = 2'd1, DATA = 2'd2} line_mode_t;

  logic [20:1] ptr_r      [8];
  logic [20:1] ptr_nx_s   [8];
  logic [8:0]  vstart_r   [8];
  logic [8:0]  vstart_nx_s[8];
  logic [8:0]  vstop_r    [8];
  logic [8:0]  vstop_nx_s [8];
  spr_state_t  state_r    [8];
  spr_state_t  state_nx_s [8];
  line_mode_t  mode_r     [8];
  line_mode_t  mode_nx_s  [8];

  logic [7:0]  hcc_s;
  logic [7:0]  slot_off_s;
  logic        in_slot_s;
  logic        fetch_cyc_s;
  logic        word1_s;
  logic [2:0]  spr_s;
  line_mode_t  word0_mode_s;
  line_mode_t  cur_mode_s;
  logic [1:0]  ofs_s;
  logic        dma_s;

  logic [7:0]  pt_rel_s;
  logic        pt_hit_s;
  logic [7:0]  pc_rel_s;
  logic        pos_hit_s;
  logic        ctl_hit_s;

  // Slots sit on odd colour clocks; the request is made in the hpos[0]=0 half.
  assign hcc_s       = bus.hpos[8:1];
  assign slot_off_s  = hcc_s - SPRSLOTSTART;
  assign in_slot_s   = hcc_s[0] && (slot_off_s <= 8'd30);
  assign fetch_cyc_s = in_slot_s && !bus.hpos[0];
  assign spr_s       = in_slot_s ? slot_off_s[4:2] : 3'd0;
  assign word1_s     = slot_off_s[1];

  assign pt_rel_s  = bus.reg_address_in - SPRPTBASE[8:1];
  assign pt_hit_s  = (pt_rel_s < 8'd16);
  assign pc_rel_s  = bus.reg_address_in - SPRPOSCTLBASE[8:1];
  assign pos_hit_s = (pc_rel_s < 8'd32) && (pc_rel_s[1:0] == 2'd0);
  assign ctl_hit_s = (pc_rel_s < 8'd32) && (pc_rel_s[1:0] == 2'd1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        ptr_r[i]    <= 20'd0;
        vstart_r[i] <= 9'd0;
        vstop_r[i]  <= 9'd0;
        state_r[i]  <= WAIT;
        mode_r[i]   <= NONE;
      end
    end else begin
      ptr_r    <= ptr_nx_s;
      vstart_r <= vstart_nx_s;
      vstop_r  <= vstop_nx_s;
      state_r  <= state_nx_s;
      mode_r   <= mode_nx_s;
    end
  end

  // Line-mode decision and request decode for the current slot
  always_comb begin
    word0_mode_s = NONE;
    if (!bus.dmaen) begin
      word0_mode_s = NONE;
    end else if (bus.vbl_end) begin
      word0_mode_s = CTL;
    end else if (state_r[spr_s] == ARMED && bus.vpos == vstop_r[spr_s]) begin
      word0_mode_s = CTL;
    end else if (state_r[spr_s] == ARMED) begin
      word0_mode_s = DATA;
    end else if (bus.vpos == vstart_r[spr_s] && vstart_r[spr_s] != vstop_r[spr_s]) begin
      word0_mode_s = DATA;
    end else begin
      word0_mode_s = NONE;
    end

    cur_mode_s = NONE;
    if (reset || !fetch_cyc_s) begin
      cur_mode_s = NONE;
    end else if (word1_s) begin
      cur_mode_s = bus.dmaen ? mode_r[spr_s] : NONE;
    end else begin
      cur_mode_s = word0_mode_s;
    end

    // DATA fetches DATB first so the sprite only arms once both words are loaded.
    ofs_s = 2'd0;
    case (cur_mode_s)
      CTL:     ofs_s = {1'b0, word1_s};
      DATA:    ofs_s = word1_s ? 2'd2 : 2'd3;
      default: ofs_s = 2'd0;
    endcase
  end

  assign dma_s               = (cur_mode_s != NONE);
  assign bus.dma             = dma_s;
  assign bus.reg_address_out = dma_s ? (SPRPOSCTLBASE[8:1] + {3'b000, spr_s, 2'b00} + {6'b000000, ofs_s})
                                     : 8'hFF;
  assign bus.address_out     = ptr_r[spr_s];

  // Next-state: pointer advance, arming, and register-bus snooping
  always_comb begin
    ptr_nx_s    = ptr_r;
    vstart_nx_s = vstart_r;
    vstop_nx_s  = vstop_r;
    state_nx_s  = state_r;
    mode_nx_s   = mode_r;
    if (clk7_en) begin
      if (dma_s) begin
        ptr_nx_s[spr_s] = ptr_r[spr_s] + 20'd1;
      end else begin
        ptr_nx_s[spr_s] = ptr_r[spr_s];
      end
      if (fetch_cyc_s && !word1_s) begin
        mode_nx_s[spr_s] = word0_mode_s;
        if (word0_mode_s == DATA) begin
          state_nx_s[spr_s] = ARMED;
        end else begin
          state_nx_s[spr_s] = state_r[spr_s];
        end
      end else if (fetch_cyc_s) begin
        mode_nx_s[spr_s] = NONE;
      end else begin
        mode_nx_s[spr_s] = mode_r[spr_s];
      end
      // A pointer write overrides this cycle's increment.
      if (pt_hit_s && pt_rel_s[0]) begin
        ptr_nx_s[pt_rel_s[3:1]] = {ptr_r[pt_rel_s[3:1]][20:16], bus.data_in[15:1]};
      end else if (pt_hit_s) begin
        ptr_nx_s[pt_rel_s[3:1]] = {bus.data_in[4:0], ptr_r[pt_rel_s[3:1]][15:1]};
      end else begin
        ptr_nx_s[spr_s] = ptr_nx_s[spr_s];
      end
      if (pos_hit_s) begin
        vstart_nx_s[pc_rel_s[4:2]][7:0] = bus.data_in[15:8];
      end else if (ctl_hit_s) begin
        vstop_nx_s[pc_rel_s[4:2]]     = {bus.data_in[1], bus.data_in[15:8]};
        vstart_nx_s[pc_rel_s[4:2]][8] = bus.data_in[2];
        state_nx_s[pc_rel_s[4:2]]     = WAIT;
      end else begin
        vstop_nx_s[spr_s] = vstop_r[spr_s];
      end
    end else begin
      ptr_nx_s = ptr_r;
    end
  end
endmodule
